// File: rtl/arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arb_pkg : shared types/constants for the 8-way round-robin arbiter  (rev 1.0)
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int N    = 8;
  localparam int IDXW = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Pointer moves one below the winner so the winner becomes lowest priority.
  function automatic logic [IDXW-1:0] wrap_dec(input logic [IDXW-1:0] idx);
    return (idx == '0) ? IDXW'(N - 1) : idx - IDXW'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rot_prio_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rot_prio_enc : 8-to-3 priority encoder, search descending from ptr  (rev 1.0)
// ---------------------------------------------------------------------------
module rot_prio_enc
  import arb_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            any_valid
);

  always_comb begin
    idx       = '0;
    any_valid = 1'b0;
    // Index arithmetic is modulo 8, so ptr - i wraps from 0 back to 7.
    for (int i = 0; i < N; i++) begin
      if (!any_valid && req[ptr - IDXW'(i)]) begin
        any_valid = 1'b1;
        idx       = ptr - IDXW'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter8 : 8-requester round-robin arbiter with bounded hold time  (rev 1.0)
// ---------------------------------------------------------------------------
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int RR_EN    = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam int             HCW       = $clog2(MAX_HOLD + 2);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t          state, state_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic [HCW-1:0]  hold_cnt, hold_nxt;
  logic [N-1:0]    gnt_nxt;
  logic [IDXW-1:0] idx_nxt;
  logic            timeout_nxt;
  logic [IDXW-1:0] win_idx;
  logic            win_valid;

  rot_prio_enc u_enc (
    .req       (req),
    .ptr       (ptr),
    .idx       (win_idx),
    .any_valid (win_valid)
  );

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt;
    idx_nxt     = gnt_idx;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (win_valid) begin
          state_nxt = GRANT;
          gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << win_idx;
          idx_nxt   = win_idx;
          hold_nxt  = '0;
          ptr_nxt   = (RR_EN != 0) ? wrap_dec(win_idx) : IDXW'(N - 1);
        end
      end
      GRANT: begin
        if (hold_cnt != '1) hold_nxt = hold_cnt + 1'b1;
        // Release wins over timeout when both occur on the same cycle.
        if (!req[gnt_idx]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          timeout_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= IDXW'(N - 1);
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_idx  <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gnt_idx  <= idx_nxt;
      timeout  <= timeout_nxt;
    end
  end

  assign gnt_valid = |gnt;

endmodule
`default_nettype wire
